// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: skid register state encoding and default widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int PIPE_W_IFID = 64;

endpackage : pipe_pkg

// File: rtl/pipe_skid_reg.sv
// Generic pipeline stage register: valid/ready handshake, two-entry skid buffer,
// registered in_ready and synchronous flush that inserts a bubble.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W        = PIPE_W_IFID,
  parameter bit ZERO_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  pipe_state_e       state_r;
  pipe_state_e       state_nxt_s;
  logic [DATA_W-1:0] main_r;
  logic [DATA_W-1:0] main_nxt_s;
  logic [DATA_W-1:0] skid_r;
  logic [DATA_W-1:0] skid_nxt_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              accept_s;
  logic              emit_s;

  assign accept_s  = in_valid & in_ready_r;
  assign emit_s    = out_valid_r & out_ready;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;

  // Next-state and payload steering; clr beats flush beats normal handshake.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    if (clr) begin
      state_nxt_s = ST_EMPTY;
      main_nxt_s  = {DATA_W{1'b0}};
      skid_nxt_s  = {DATA_W{1'b0}};
    end else if (flush) begin
      state_nxt_s = ST_EMPTY;
      if (ZERO_ON_FLUSH) begin
        main_nxt_s = {DATA_W{1'b0}};
        skid_nxt_s = {DATA_W{1'b0}};
      end else begin
        main_nxt_s = main_r;
        skid_nxt_s = skid_r;
      end
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s = ST_ONE;
            main_nxt_s  = in_data;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && !emit_s) begin
            state_nxt_s = ST_FULL;
            skid_nxt_s  = in_data;
          end else if (accept_s && emit_s) begin
            state_nxt_s = ST_ONE;
            main_nxt_s  = in_data;
          end else if (emit_s) begin
            // main keeps the emitted payload so out_data holds it while empty
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (emit_s) begin
            state_nxt_s = ST_ONE;
            main_nxt_s  = skid_r;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State, payload and handshake flags; flags decoded from next state so both stay registered.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r     <= ST_EMPTY;
      main_r      <= {DATA_W{1'b0}};
      skid_r      <= {DATA_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      skid_r      <= skid_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_FULL);
      out_valid_r <= (state_nxt_s == ST_ONE) || (state_nxt_s == ST_FULL);
    end
  end

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: queue-based stage model plus a scoreboard monitor.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        clr, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic        b_clr, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model_q[$];
  logic [63:0] last_data;
  logic        acc;
  int          k;

  always #5 clk = ~clk;

  pipe_skid_reg u_dut (
    .clk(clk), .clr(clr), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  pipe_skid_reg #(.DATA_W(32), .ZERO_ON_FLUSH(1'b0)) u_dut_b (
    .clk(clk), .clr(b_clr), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle: check outputs against the model, drive inputs, then advance the model.
  task automatic step(input logic iv, input logic [63:0] d, input logic ordy,
                      input logic fl, input logic cl, output logic accepted);
    logic em;
    int   n;
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
    if (model_q.size() == 0) chk("idle_data", out_data, last_data);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    clr       = cl;
    #2;
    accepted = iv && (model_q.size() < 2) && !fl && !cl;
    em       = ordy && (model_q.size() > 0);
    if (em) last_data = model_q.pop_front();
    if (cl || fl) begin
      n = model_q.size();
      repeat (n) if (exp_q.size() > 0) void'(exp_q.pop_back());
      model_q.delete();
      last_data = 64'd0;
    end else if (accepted) begin
      model_q.push_back(d);
      exp_q.push_back(d);
    end
  endtask

  // Scoreboard monitor: every presented payload must match the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h, expected no valid output", out_data);
        end else begin
          chk("out_data", out_data, exp_q[0]);
          if (out_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    clr = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b0;
    b_clr = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 32'd0; b_out_ready = 1'b0;
    last_data = 64'd0;

    // reset then a single payload
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 64'hA5A5_0000_0000_0004, 1'b1, 1'b0, 1'b0, acc);
    step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, acc);
    step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, acc);

    // back-pressure: stream 1..4 while downstream stalls, then release
    k = 1;
    for (int c = 0; c < 12; c++) begin
      step(k <= 4, 64'(k), c >= 4, 1'b0, 1'b0, acc);
      if (acc) k++;
    end

    // full throughput
    for (int i = 0; i < 16; i++) step(1'b1, 64'h100 + 64'(i), 1'b1, 1'b0, 1'b0, acc);
    step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, acc);
    step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, acc);

    // flush while FULL with a colliding input
    step(1'b1, 64'd7, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 64'd8, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 64'd9, 1'b0, 1'b1, 1'b0, acc);
    step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, acc);

    // clr and flush together while emitting from ONE
    step(1'b1, 64'd5, 1'b0, 1'b0, 1'b0, acc);
    step(1'b0, 64'd0, 1'b1, 1'b1, 1'b1, acc);
    step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, acc);

    // randomized traffic with occasional flush/clr
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0, acc);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, acc);

    // 32-bit instance that keeps payload on flush
    @(negedge clk);
    b_clr = 1'b0; b_in_valid = 1'b1; b_in_data = 32'hDEAD_BEEF;
    @(negedge clk);
    b_in_valid = 1'b0;
    chk("b_one_valid", 64'(b_out_valid), 64'd1);
    chk("b_one_data", 64'(b_out_data), 64'h0000_0000_DEAD_BEEF);
    b_flush = 1'b1;
    @(negedge clk);
    b_flush = 1'b0;
    chk("b_flush_valid", 64'(b_out_valid), 64'd0);
    chk("b_flush_ready", 64'(b_in_ready), 64'd1);
    chk("b_flush_data", 64'(b_out_data), 64'h0000_0000_DEAD_BEEF);
    b_in_valid = 1'b1; b_in_data = 32'h1111_1111;
    @(negedge clk);
    b_in_data = 32'h2222_2222;
    @(negedge clk);
    b_in_valid = 1'b0;
    chk("b_full_ready", 64'(b_in_ready), 64'd0);
    chk("b_full_data", 64'(b_out_data), 64'h0000_0000_1111_1111);
    b_flush = 1'b1; b_in_valid = 1'b1; b_in_data = 32'h3333_3333;
    @(negedge clk);
    b_flush = 1'b0; b_in_valid = 1'b0;
    chk("b_fflush_valid", 64'(b_out_valid), 64'd0);
    chk("b_fflush_ready", 64'(b_in_ready), 64'd1);
    chk("b_fflush_data", 64'(b_out_data), 64'h0000_0000_1111_1111);
    @(negedge clk);
    chk("b_bubble_hold", 64'(b_out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pipe_skid_reg

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with valid/ready handshake, a two-entry skid buffer and synchronous flush. It replaces the fixed 64-bit stage latches between pipeline stages (IF/ID, ID/EX, …) with a single generic block. It gives full throughput under back-pressure, a registered `in_ready` so no combinational ready path crosses stages, and bubble insertion on flush. The payload is opaque, for example `{instr, pc4}` for IF/ID.

## Interface

Parameters:
- `DATA_W`, 64, payload width in bits (≥1)
- `ZERO_ON_FLUSH`, 1, when 1, flush/reset forces both payload registers to 0; when 0, payload registers keep their value and only valid state clears

Ports:
- `clk`, input, 1, single clock; all state updates on posedge
- `clr`, input, 1, synchronous active-high reset; one clock; reset is synchronous and active-high
- `flush`, input, 1, synchronous bubble insert; discards all held and incoming data
- `in_valid`, input, 1, upstream has payload
- `in_ready`, output, 1, stage can accept; driven directly from a register
- `in_data`, input, DATA_W, upstream payload
- `out_valid`, output, 1, `out_data` is valid
- `out_ready`, input, 1, downstream accepts (deasserted = stall)
- `out_data`, output, DATA_W, registered payload to next stage

## Operation

- accept = `in_valid & in_ready`; emit = `out_valid & out_ready`.
- Storage: `main` (drives `out_data`) and `skid`. States:
  - EMPTY: `out_valid`=0, `in_ready`=1
  - ONE: `out_valid`=1, `in_ready`=1
  - FULL: `out_valid`=1, `in_ready`=0
- Transitions (no clr/flush):
  - EMPTY: accept → ONE, `main`<=`in_data`; otherwise hold.
  - ONE, accept & !emit: → FULL, `skid`<=`in_data`.
  - ONE, accept & emit: stay ONE, `main`<=`in_data`.
  - ONE, !accept & emit: → EMPTY.
  - ONE, idle: hold.
  - FULL, emit: → ONE, `main`<=`skid`.
  - FULL, !emit: hold. No accept is possible in FULL.
- Priority: `clr` > `flush` > normal.
- `clr` or `flush` → EMPTY next cycle, `in_ready`=1, `out_valid`=0.
  - If ZERO_ON_FLUSH=1, `main` and `skid` are set to 0.
  - An `in_data` presented in that cycle is dropped, even if `in_valid` & `in_ready`.
  - An emit in that same cycle still counts as consumed downstream.
- Reset values: `out_valid`=0, `in_ready`=1, `out_data`=0 (both registers 0 regardless of ZERO_ON_FLUSH).
- In EMPTY after a normal drain, `out_data` retains the last emitted payload. It is not zeroed.
- Ordering is strict FIFO: no payload is duplicated or lost except by flush or clr.
- Payload is passed bit-exact; the block performs no arithmetic on it.

## Timing

- Latency: `in_data` accepted at edge N appears on `out_data` with `out_valid`=1 after edge N, i.e. in cycle N+1.
- Throughput: 1 payload/cycle sustained while `out_ready`=1.
- Stall: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` are held stable every cycle.
- `in_ready` falls the cycle after the second accept without emit. It rises the cycle after the first emit from FULL.
- `in_ready` does not depend combinationally on `out_ready`.
- Flush takes effect on the edge where `flush`=1. A bubble (`out_valid`=0) is visible in the following cycle.
- `clr` or `flush` held for several cycles keeps the stage EMPTY.
- Mid-operation reset behaves identically from any state.

## Structure

- Shared package `pipe_pkg`: state typedef with encodings `ST_EMPTY`=2'd0, `ST_ONE`=2'd1, `ST_FULL`=2'd2, plus the default width constant `PIPE_W_IFID`=64.
- Single module. No sub-module: the two payload registers and the 2-bit state fit naturally in one block.
- Encoding 2'd3 is illegal and recovers to EMPTY on the next edge.

## Test plan

- Reset/basic: `clr`=1 for 2 cycles, then `in_valid`=1, `in_data`=64'hA5A5_0000_0000_0004, `out_ready`=1 → cycle after accept: `out_valid`=1, `out_data`=64'hA5A5_0000_0000_0004. During reset: `in_ready`=1, `out_data`=0.
- Back-pressure: stream 1,2,3,4 with `out_ready`=0 from cycle 1 → accepts 1,2, then `in_ready`=0. `out_data`=1 stable. Raise `out_ready` → output sequence exactly 1,2,3,4 with no gap after release.
- Full throughput: 16 back-to-back payloads, `out_ready`=1 → 16 outputs on consecutive cycles, `in_ready` constantly 1.
- Flush in FULL: state FULL holding 7,8, with `flush`=1 and `in_valid`=1, `in_data`=9 → next cycle `out_valid`=0, `in_ready`=1. With ZERO_ON_FLUSH=1, `out_data`=0. Payloads 7, 8 and 9 never appear.
- Simultaneous `clr` & `flush`, plus emit in ONE → EMPTY, all registers 0. Emitted payload counted once by the scoreboard.
- ZERO_ON_FLUSH=0, DATA_W=32: flush while ONE holding 32'hDEAD_BEEF → `out_valid`=0, `out_data` stays 32'hDEAD_BEEF.
